// File: rtl/traffic_light_seq.sv
// Traffic-light sequencer for NUM_DIR approaches: ALLRED -> GREEN -> YELLOW rotation,
// priority-request green truncation, night-mode flashing yellow and a tick countdown.
module traffic_light_seq #(
  parameter int unsigned NUM_DIR       = 2,
  parameter int unsigned TICK_DIV      = 125000000,
  parameter int unsigned GREEN_SEC     = 10,
  parameter int unsigned YELLOW_SEC    = 3,
  parameter int unsigned ALLRED_SEC    = 1,
  parameter int unsigned MIN_GREEN_SEC = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                       clk_125M,
  input  logic                       rst,
  input  logic                       key_valid,
  input  logic [$clog2(NUM_DIR)-1:0] key_value,
  input  logic                       night_mode,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [CNT_W-1:0]           sec_remaining,
  output logic                       phase_change
);

  localparam int unsigned DW = $clog2(NUM_DIR);
  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_ALLRED,
    S_GREEN,
    S_YELLOW,
    S_FLASH
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q;
  logic               tick;
  logic [DW-1:0]      dir_d;
  logic [CNT_W-1:0]   sec_d;
  logic               pending_q, pending_d;
  logic               flash_q, flash_d;
  logic               pc_d;
  logic               key_in_range;
  logic               req_ok;
  logic               pending_eff;
  logic [NUM_DIR-1:0] dir_mask;
  logic [NUM_DIR-1:0] red_d, yellow_d, green_d;

  // Prescaler: tick is high for the single cycle the count sits at TICK_DIV-1.
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_125M or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  if ((1 << DW) == NUM_DIR) begin : g_key_pow2
    assign key_in_range = 1'b1;
  end else begin : g_key_npow2
    assign key_in_range = (key_value <= DW'(NUM_DIR - 1));
  end

  assign req_ok = key_valid && key_in_range && (key_value != active_dir)
                  && (state_q != S_FLASH);

  // A request is honoured in the cycle it arrives, so truncation lands one edge later.
  assign pending_eff = pending_q | req_ok;

  always_comb begin
    state_d   = state_q;
    dir_d     = active_dir;
    sec_d     = sec_remaining;
    pending_d = pending_eff;
    flash_d   = flash_q;
    pc_d      = 1'b0;

    if (tick) begin
      if (night_mode) begin
        pending_d = 1'b0;
        if (state_q != S_FLASH) begin
          state_d = S_FLASH;
          sec_d   = '0;
          flash_d = 1'b1;
          pc_d    = 1'b1;
        end else begin
          flash_d = ~flash_q;
        end
      end else if (state_q == S_FLASH) begin
        state_d   = S_ALLRED;
        sec_d     = CNT_W'(ALLRED_SEC);
        flash_d   = 1'b0;
        pending_d = 1'b0;
        pc_d      = 1'b1;
      end else if (sec_remaining > CNT_W'(1)) begin
        sec_d = sec_remaining - CNT_W'(1);
      end else begin
        pc_d = 1'b1;
        unique case (state_q)
          S_ALLRED: begin
            state_d   = S_GREEN;
            dir_d     = (active_dir == DW'(NUM_DIR - 1)) ? '0 : active_dir + DW'(1);
            sec_d     = CNT_W'(GREEN_SEC);
            pending_d = 1'b0;
          end
          S_GREEN: begin
            state_d = S_YELLOW;
            sec_d   = CNT_W'(YELLOW_SEC);
          end
          S_YELLOW: begin
            state_d = S_ALLRED;
            sec_d   = CNT_W'(ALLRED_SEC);
          end
          default: begin
            state_d = S_ALLRED;
            sec_d   = CNT_W'(ALLRED_SEC);
          end
        endcase
      end
    end else if ((state_q == S_GREEN) && pending_eff
                 && (sec_remaining > CNT_W'(MIN_GREEN_SEC))) begin
      sec_d = CNT_W'(MIN_GREEN_SEC);
    end
  end

  // Lamps are decoded from the next state so they register alongside it.
  always_comb begin
    dir_mask = {{(NUM_DIR-1){1'b0}}, 1'b1} << dir_d;
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    unique case (state_d)
      S_GREEN: begin
        red_d   = ~dir_mask;
        green_d = dir_mask;
      end
      S_YELLOW: begin
        red_d    = ~dir_mask;
        yellow_d = dir_mask;
      end
      S_FLASH: begin
        red_d    = '0;
        yellow_d = {NUM_DIR{flash_d}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_125M or posedge rst) begin
    if (rst) begin
      state_q       <= S_ALLRED;
      active_dir    <= DW'(NUM_DIR - 1);
      sec_remaining <= CNT_W'(ALLRED_SEC);
      pending_q     <= 1'b0;
      flash_q       <= 1'b0;
      red           <= '1;
      yellow        <= '0;
      green         <= '0;
      phase_change  <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_dir    <= dir_d;
      sec_remaining <= sec_d;
      pending_q     <= pending_d;
      flash_q       <= flash_d;
      red           <= red_d;
      yellow        <= yellow_d;
      green         <= green_d;
      phase_change  <= pc_d;
    end
  end

endmodule
